// File: rtl/ram_arbiter.sv
// ram_arbiter: shares a single-port RAM between two burst requesters with round-robin tie-breaking.
module ram_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 6
) (
    input  logic              arb_clk,
    input  logic              arb_reset,
    input  logic              rq0_req,
    input  logic              rq0_we,
    input  logic [ADDR_W-1:0] rq0_addr,
    input  logic [LEN_W-1:0]  rq0_len,
    input  logic [DATA_W-1:0] rq0_wdata,
    output logic              rq0_gnt,
    output logic              rq0_beat,
    output logic              rq0_rvalid,
    output logic              rq0_done,
    input  logic              rq1_req,
    input  logic              rq1_we,
    input  logic [ADDR_W-1:0] rq1_addr,
    input  logic [LEN_W-1:0]  rq1_len,
    input  logic [DATA_W-1:0] rq1_wdata,
    output logic              rq1_gnt,
    output logic              rq1_beat,
    output logic              rq1_rvalid,
    output logic              rq1_done,
    output logic [DATA_W-1:0] arb_rdata,
    output logic [ADDR_W-1:0] arb_mem_address,
    output logic              arb_mem_we,
    output logic [DATA_W-1:0] arb_mem_data_in,
    input  logic [DATA_W-1:0] arb_mem_data_out
);
    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;
    state_t state, state_nx;
    logic owner, we_q, last_grant, rv0, rv1, pick, any_req, last_beat, in_burst, active;
    logic [ADDR_W-1:0] base;
    logic [LEN_W-1:0] len_q, cnt;
    assign any_req = rq0_req | rq1_req;
    assign pick = (rq0_req & rq1_req) ? ~last_grant : rq1_req;
    // len 0 wraps to 2^LEN_W beats naturally: last beat is cnt == len-1 modulo 2^LEN_W
    assign last_beat = cnt == len_q - LEN_W'(1);
    always_ff @(posedge arb_clk or negedge arb_reset) begin
        if (!arb_reset)
            state <= IDLE;
        else
            state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        in_burst = state == BURST;
        active = state != IDLE;
        case (state)
            IDLE:    state_nx = any_req ? BURST : IDLE;
            BURST:   state_nx = last_beat ? DRAIN : BURST;
            default: state_nx = IDLE;
        endcase
        rq0_gnt = active & ~owner;
        rq1_gnt = active & owner;
        rq0_beat = in_burst & ~owner;
        rq1_beat = in_burst & owner;
        rq0_done = (state == DRAIN) & ~owner;
        rq1_done = (state == DRAIN) & owner;
        rq0_rvalid = rv0;
        rq1_rvalid = rv1;
        arb_mem_we = in_burst & we_q;
        arb_mem_address = in_burst ? base + ADDR_W'(cnt) : '0;
        arb_mem_data_in = arb_mem_we ? (owner ? rq1_wdata : rq0_wdata) : '0;
        arb_rdata = arb_mem_data_out;
    end
    always_ff @(posedge arb_clk or negedge arb_reset) begin
        if (!arb_reset) begin
            owner <= 1'b0;
            we_q <= 1'b0;
            base <= '0;
            len_q <= '0;
            cnt <= '0;
            last_grant <= 1'b1;
            rv0 <= 1'b0;
            rv1 <= 1'b0;
        end else begin
            rv0 <= rq0_beat & ~we_q;
            rv1 <= rq1_beat & ~we_q;
            if (state == IDLE && any_req) begin
                owner <= pick;
                last_grant <= pick;
                we_q <= pick ? rq1_we : rq0_we;
                base <= pick ? rq1_addr : rq0_addr;
                len_q <= pick ? rq1_len : rq0_len;
                cnt <= '0;
            end else if (in_burst) begin
                cnt <= cnt + LEN_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: randomized and directed bench for ram_arbiter against a burst-timeline reference model.
module tb_ram_arbiter;
    logic clk, rst_n;
    logic req[2], we[2], gnt[2], beat[2], rv[2], done[2];
    logic [5:0] addr[2], len[2];
    logic [31:0] wdata[2], wd_base[2];
    logic [31:0] arb_rdata, mem_din, mem_dout;
    logic [5:0] mem_addr;
    logic mem_we;
    logic [31:0] ram[64] = '{default: 32'd0};
    logic [31:0] ref_mem[64] = '{default: 32'd0};
    logic [31:0] rd_log[65];
    int n_vec = 0, n_err = 0, cyc = 0, nrv;
    // reference model: a granted burst is a timeline anchored at its first beat cycle
    bit busy = 0;
    logic last_grant = 1, m_owner = 0, m_we = 0;
    logic [5:0] m_base = 0;
    int start = 0, m_len = 0;
    logic pend_we = 0;
    logic [5:0] pend_a;
    logic [31:0] pend_d;
    wire logic [8:0] ctl_obs = {gnt[0], beat[0], rv[0], done[0], gnt[1], beat[1], rv[1], done[1], mem_we};

    ram_arbiter dut (
        .arb_clk(clk), .arb_reset(rst_n),
        .rq0_req(req[0]), .rq0_we(we[0]), .rq0_addr(addr[0]), .rq0_len(len[0]), .rq0_wdata(wdata[0]),
        .rq0_gnt(gnt[0]), .rq0_beat(beat[0]), .rq0_rvalid(rv[0]), .rq0_done(done[0]),
        .rq1_req(req[1]), .rq1_we(we[1]), .rq1_addr(addr[1]), .rq1_len(len[1]), .rq1_wdata(wdata[1]),
        .rq1_gnt(gnt[1]), .rq1_beat(beat[1]), .rq1_rvalid(rv[1]), .rq1_done(done[1]),
        .arb_rdata(arb_rdata), .arb_mem_address(mem_addr), .arb_mem_we(mem_we),
        .arb_mem_data_in(mem_din), .arb_mem_data_out(mem_dout)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    always @(posedge clk) if (pend_we && rst_n) ref_mem[pend_a] = pend_d;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : model
        int d;
        logic bt, dn, g, rvx, o;
        logic [5:0] ea;
        logic [31:0] ed;
        if (!rst_n) begin
            busy = 0;
            last_grant = 1;
            pend_we = 0;
            check("rst_ctl", 64'(ctl_obs), 0);
            check("rst_addr", 64'(mem_addr), 0);
            check("rst_din", 64'(mem_din), 0);
        end else begin
            d = cyc - start;
            if (busy && d > m_len) busy = 0;
            o = m_owner;
            g = busy;
            bt = busy && d < m_len;
            dn = busy && d == m_len;
            rvx = busy && !m_we && d >= 1;
            ea = bt ? 6'(int'(m_base) + d) : 6'd0;
            ed = (bt && m_we) ? wdata[o] : 32'd0;
            check("ctl", 64'(ctl_obs), 64'({g && !o, bt && !o, rvx && !o, dn && !o, g && o, bt && o, rvx && o, dn && o, bt && m_we}));
            check("addr", 64'(mem_addr), 64'(ea));
            check("din", 64'(mem_din), 64'(ed));
            if (rvx) check("rdata", 64'(arb_rdata), 64'(ref_mem[6'(int'(m_base) + d - 1)]));
            pend_we = bt && m_we;
            pend_a = ea;
            pend_d = ed;
            if (!busy && (req[0] || req[1])) begin
                m_owner = (req[0] && req[1]) ? !last_grant : req[1];
                last_grant = m_owner;
                busy = 1;
                start = cyc + 1;
                m_we = we[m_owner];
                m_base = addr[m_owner];
                m_len = len[m_owner] == 0 ? 64 : int'(len[m_owner]);
            end
        end
        cyc++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
        for (int n = 0; n < 2; n++)
            wdata[n] = (busy && m_owner == n) ? wd_base[n] + 32'(cyc - start) : $urandom;
    endtask

    task automatic run_burst(input int n, input int exp_beats);
        int nb;
        bit fin;
        nb = 0;
        fin = 0;
        nrv = 0;
        for (int i = 0; i < 300 && !fin; i++) begin
            tick;
            if (gnt[n]) req[n] = 0;
            if (beat[n]) nb++;
            if (rv[n]) begin
                rd_log[nrv] = arb_rdata;
                nrv++;
            end
            if (done[n]) fin = 1;
        end
        check("done_seen", 64'(fin), 1);
        check("beat_cnt", 64'(nb), 64'(exp_beats));
    endtask

    initial begin
        int prev, ngr;
        bit was;
        rst_n = 0;
        for (int n = 0; n < 2; n++) begin
            wdata[n] = 0;
            wd_base[n] = $urandom;
        end
        req[0] = 1; we[0] = 1; addr[0] = 5; len[0] = 5; wd_base[0] = 32'h7FFF_FFFF;
        req[1] = 1; we[1] = 0; addr[1] = 5; len[1] = 5;
        repeat (5) tick;
        rst_n = 1;
        tick;
        check("first_tie_gnt0", 64'(gnt[0]), 1);
        req[0] = 0;
        run_burst(0, 4);
        run_burst(1, 5);
        check("rv_cnt", 64'(nrv), 5);
        for (int i = 0; i < 5; i++) check("rd_seq", 64'(rd_log[i]), 64'(32'h7FFF_FFFF + 32'(i)));

        req[0] = 1; req[1] = 1; we[0] = 0; we[1] = 0; len[0] = 2; len[1] = 2;
        addr[0] = 6'($urandom); addr[1] = 6'($urandom);
        prev = -1;
        ngr = 0;
        was = 0;
        for (int i = 0; i < 40; i++) begin
            tick;
            if ((gnt[0] || gnt[1]) && !was) begin
                if (prev >= 0) check("alternate", 64'(gnt[1]), 64'(prev == 0));
                prev = int'(gnt[1]);
                ngr++;
            end
            was = gnt[0] || gnt[1];
        end
        check("alt_cnt", 64'(ngr >= 8), 1);
        req[0] = 0; req[1] = 0;
        repeat (6) tick;

        req[0] = 1; we[0] = 1; addr[0] = 62; len[0] = 3; wd_base[0] = $urandom;
        run_burst(0, 3);
        req[1] = 1; we[1] = 0; addr[1] = 0; len[1] = 0;
        run_burst(1, 64);
        check("rv64", 64'(nrv), 64);

        req[0] = 1; we[0] = 1; addr[0] = 20; len[0] = 5; wd_base[0] = 32'hA5A5_0000;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (gnt[0]) break;
        end
        check("gnt_seen", 64'(gnt[0]), 1);
        req[0] = 0;
        tick;
        tick;
        check("beat2", 64'({beat[0], mem_addr}), 64'({1'b1, 6'd22}));
        rst_n = 0;
        #1;
        check("abort_we", 64'(mem_we), 0);
        check("abort_gnt", 64'(gnt[0]), 0);
        repeat (3) begin
            tick;
            check("no_done", 64'(done[0]), 0);
        end
        rst_n = 1;
        req[1] = 1; we[1] = 0; addr[1] = 20; len[1] = 5;
        run_burst(1, 5);
        check("rb_cnt", 64'(nrv), 5);
        check("rb0", 64'(rd_log[0]), 64'h A5A5_0000);
        check("rb1", 64'(rd_log[1]), 64'h A5A5_0001);
        for (int i = 2; i < 5; i++) check("rb_unwritten", 64'(rd_log[i]), 0);

        for (int i = 0; i < 1500; i++) begin
            tick;
            rst_n = $urandom_range(400) != 0;
            for (int n = 0; n < 2; n++)
                if ($urandom_range(3) == 0) begin
                    req[n] = 1'($urandom_range(1));
                    we[n] = 1'($urandom);
                    addr[n] = 6'($urandom);
                    len[n] = $urandom_range(15) == 0 ? 6'd0 : 6'($urandom_range(6, 1));
                    wd_base[n] = $urandom;
                end
        end
        rst_n = 1;
        req[0] = 0; req[1] = 0;
        repeat (80) tick;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port RAM between two requesters: rq0 (memory-controller load path) and rq1 (processing-core operand fetch).
- Accepts burst requests as base address, length and direction.
- Grants one requester at a time, with round-robin on ties.
- Drives the RAM address, write-enable and write data, and returns read data with a 1-cycle valid.

Parameters:
- ADDR_W, 6: RAM address width (64 words).
- DATA_W, 32: data word width.
- LEN_W, 6: burst length field width. Length 0 encodes 2^LEN_W (64) beats.

Ports:
- arb_clk  in  1  clock.
- arb_reset  in  1  asynchronous active-low reset.
- rq0_req  in  1  burst request from requester 0.
- rq0_we  in  1  1 = write burst, 0 = read burst; sampled with rq0_req.
- rq0_addr  in  ADDR_W  burst base address.
- rq0_len  in  LEN_W  beat count.
- rq0_wdata  in  DATA_W  write data for the current beat.
- rq0_gnt  out  1  high for the whole granted burst.
- rq0_beat  out  1  high in each cycle a beat is issued; for writes, the requester advances wdata on it.
- rq0_rvalid  out  1  read data valid on arb_rdata.
- rq0_done  out  1  1-cycle pulse at burst end.
- rq1_req, rq1_we, rq1_addr, rq1_len, rq1_wdata, rq1_gnt, rq1_beat, rq1_rvalid, rq1_done: same as rq0_*, for requester 1.
- arb_rdata  out  DATA_W  read data, equal to arb_mem_data_out.
- arb_mem_address  out  ADDR_W  RAM address.
- arb_mem_we  out  1  RAM write enable.
- arb_mem_data_in  out  DATA_W  RAM write data.
- arb_mem_data_out  in  DATA_W  RAM read data, registered, valid one cycle after the address is presented.

Behaviour:
- Reset (arb_reset=0, async):
  - state=IDLE; all outputs 0.
  - Beat counter 0; last_grant=1, so rq0 wins the first tie.
- States IDLE, BURST, DRAIN.
- IDLE:
  - Requests are sampled here only.
  - One request pending: that requester wins.
  - Both pending: the requester other than last_grant wins.
  - On a win: latch owner, we, addr, len; set last_grant=owner; go to BURST next cycle.
  - No request: stay in IDLE.
- BURST:
  - rqN_gnt=1 for the owner.
  - Each cycle issues beat k (k = 0..L-1, where L = len, or 64 if len=0).
  - arb_mem_address = base+k, mod 2^ADDR_W (wraps 63 to 0).
  - rqN_beat=1 each beat.
  - Writes: arb_mem_we=1 and arb_mem_data_in = owner's rqN_wdata, combinational pass-through.
  - After beat L-1, go to DRAIN.
- DRAIN:
  - gnt stays 1, beat=0, we=0.
  - rqN_done pulses for 1 cycle.
  - Next state IDLE.
- Timing: with req sampled in IDLE at cycle T:
  - gnt rises at T+1; beat k occurs at T+1+k.
  - done occurs at T+L+1; IDLE at T+L+2.
  - Back-to-back grants are therefore separated by one IDLE cycle.
- Reads:
  - rqN_rvalid = owner's beat registered by one cycle, reads only.
  - The last read's rvalid coincides with DRAIN/done.
  - arb_rdata is always driven from arb_mem_data_out.
- Outside BURST: arb_mem_we=0, arb_mem_address=0, arb_mem_data_in=0.
- Non-owner: all rqN_* outputs are 0.
- Deasserting req mid-burst is ignored; the burst completes.
- Req still high at done is re-arbitrated in the next IDLE cycle, so a competing requester wins under round-robin.
- Reset asserted mid-burst aborts immediately: outputs 0, no done pulse, no further RAM write.
- Request inputs change only when sampled; the arbiter does not check them for stability.

Test Plan:
- Reset: hold arb_reset=0 for 5 cycles with both reqs high -> all outputs 0, no arb_mem_we. Release -> rq0_gnt rises 1 cycle later (rq0 wins the first tie).
- rq0 write burst, addr=5, len=5, wdata=0x7FFFFFFF+k -> arb_mem_we high for 5 cycles at addresses 5..9 carrying those data. rq0_done 1 cycle after the last beat.
- rq1 read burst, addr=5, len=5 after the above -> rq1_rvalid 5 cycles, arb_rdata = 0x7FFFFFFF..0x80000003, the last one coinciding with rq1_done.
- Both reqs held high continuously, len=2 each -> grants alternate rq0, rq1, rq0, ..., with exactly 1 IDLE cycle between bursts.
- Wrap and len=0: rq0 write, addr=62, len=3 -> addresses 62, 63, 0. rq1 read, addr=0, len=0 -> 64 beats.
- Reset asserted during beat 2 of a 5-beat write -> arb_mem_we drops asynchronously, no done pulse. Post-reset readback shows only beats 0-1 written.
